// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - Q-phase instruction sequencer: opcode decode, EXEC/FLUSH control, stack-depth tracking
module instr_sequencer #(
  parameter int Q_CYCLES    = 4,
  parameter int STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] instr_current,
  input  logic        status_z,
  input  logic        bit_test_res,
  output logic        alu_sel_l,
  output logic [3:0]  alu_op,
  output logic        alu_status_wr_en,
  output logic        w_wr_en,
  output logic        f_wr_en,
  output logic        instr_rd_en,
  output logic        instr_flush,
  output logic        pc_incr_en,
  output logic        pc_j_en,
  output logic        pc_src_stack,
  output logic        stack_push,
  output logic        stack_pop,
  output logic [2:0]  q_phase,
  output logic        in_flush,
  output logic        stack_ovf,
  output logic        stack_unf,
  output logic        illegal_instr
);
  localparam logic [2:0] EXEC_Q    = 3'(Q_CYCLES - 2);
  localparam logic [2:0] LAST_Q    = 3'(Q_CYCLES - 1);
  localparam logic [4:0] DEPTH_MAX = 5'(STACK_DEPTH);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_IOR    = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_COM    = 4'd5;
  localparam logic [3:0] ALU_INC    = 4'd6;
  localparam logic [3:0] ALU_DEC    = 4'd7;
  localparam logic [3:0] ALU_RLF    = 4'd8;
  localparam logic [3:0] ALU_RRF    = 4'd9;
  localparam logic [3:0] ALU_SWAP   = 4'd10;
  localparam logic [3:0] ALU_PASSLF = 4'd11;
  localparam logic [3:0] ALU_PASSW  = 4'd12;
  localparam logic [3:0] ALU_CLR    = 4'd13;
  localparam logic [3:0] ALU_BCF    = 4'd14;
  localparam logic [3:0] ALU_BSF    = 4'd15;

  typedef enum logic {S_EXEC, S_FLUSH} state_t;
  typedef enum logic [3:0] {
    K_NOP, K_ALU, K_SKIPZ, K_SKIPB, K_GOTO, K_CALL, K_RET, K_RETLW, K_ILL
  } kind_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_q;
  logic [4:0] r_depth;
  logic       r_ovf;
  logic       r_unf;

  kind_t      w_kind;
  logic [3:0] w_op;
  logic       w_sel_l;
  logic       w_status;
  logic       w_wr_w;
  logic       w_wr_f;
  logic       w_skip;

  always_comb begin
    w_kind   = K_ILL;
    w_op     = ALU_ADD;
    w_sel_l  = 1'b0;
    w_status = 1'b0;
    w_wr_w   = 1'b0;
    w_wr_f   = 1'b0;
    case (instr_current[13:12])
      2'b00: begin
        if (instr_current[11:8] == 4'b0000) begin
          if (instr_current[7]) begin
            w_kind = K_ALU;
            w_op   = ALU_PASSW;
            w_wr_f = 1'b1;
          end else if (instr_current[6:0] == 7'h08) begin
            w_kind = K_RET;
          end else if (instr_current[4:0] == 5'h00) begin
            w_kind = K_NOP;
          end
        end else begin
          // Byte-oriented: d bit picks the destination; skip and swap forms leave STATUS alone.
          w_kind   = K_ALU;
          w_status = 1'b1;
          w_wr_f   = instr_current[7];
          w_wr_w   = ~instr_current[7];
          case (instr_current[11:8])
            4'b0001: w_op = ALU_CLR;
            4'b0010: w_op = ALU_SUB;
            4'b0011: w_op = ALU_DEC;
            4'b0100: w_op = ALU_IOR;
            4'b0101: w_op = ALU_AND;
            4'b0110: w_op = ALU_XOR;
            4'b0111: w_op = ALU_ADD;
            4'b1000: w_op = ALU_PASSLF;
            4'b1001: w_op = ALU_COM;
            4'b1010: w_op = ALU_INC;
            4'b1011: begin w_op = ALU_DEC; w_kind = K_SKIPZ; w_status = 1'b0; end
            4'b1100: w_op = ALU_RRF;
            4'b1101: w_op = ALU_RLF;
            4'b1110: begin w_op = ALU_SWAP; w_status = 1'b0; end
            4'b1111: begin w_op = ALU_INC; w_kind = K_SKIPZ; w_status = 1'b0; end
            default: ;
          endcase
        end
      end
      2'b01: begin
        case (instr_current[11:10])
          2'b00:   begin w_kind = K_ALU; w_op = ALU_BCF; w_wr_f = 1'b1; end
          2'b01:   begin w_kind = K_ALU; w_op = ALU_BSF; w_wr_f = 1'b1; end
          default: w_kind = K_SKIPB;
        endcase
      end
      2'b10: w_kind = instr_current[11] ? K_GOTO : K_CALL;
      default: begin
        casez (instr_current[11:8])
          4'b00??: begin w_kind = K_ALU;   w_op = ALU_PASSLF; w_sel_l = 1'b1; w_wr_w = 1'b1; end
          4'b01??: begin w_kind = K_RETLW; w_op = ALU_PASSLF; w_sel_l = 1'b1; w_wr_w = 1'b1; end
          4'b1000: begin w_kind = K_ALU; w_op = ALU_IOR; w_sel_l = 1'b1; w_wr_w = 1'b1; w_status = 1'b1; end
          4'b1001: begin w_kind = K_ALU; w_op = ALU_AND; w_sel_l = 1'b1; w_wr_w = 1'b1; w_status = 1'b1; end
          4'b1010: begin w_kind = K_ALU; w_op = ALU_XOR; w_sel_l = 1'b1; w_wr_w = 1'b1; w_status = 1'b1; end
          4'b110?: begin w_kind = K_ALU; w_op = ALU_SUB; w_sel_l = 1'b1; w_wr_w = 1'b1; w_status = 1'b1; end
          4'b111?: begin w_kind = K_ALU; w_op = ALU_ADD; w_sel_l = 1'b1; w_wr_w = 1'b1; w_status = 1'b1; end
          default: w_kind = K_ILL;
        endcase
      end
    endcase
  end

  assign w_skip = (w_kind == K_SKIPZ) ? status_z : bit_test_res;

  // Every strobe is gated by rst so an aborted instruction or flush never fires anything.
  always_comb begin
    alu_sel_l        = 1'b0;
    alu_op           = ALU_ADD;
    alu_status_wr_en = 1'b0;
    w_wr_en          = 1'b0;
    f_wr_en          = 1'b0;
    instr_rd_en      = 1'b0;
    instr_flush      = 1'b0;
    pc_incr_en       = 1'b0;
    pc_j_en          = 1'b0;
    pc_src_stack     = 1'b0;
    stack_push       = 1'b0;
    stack_pop        = 1'b0;
    illegal_instr    = 1'b0;
    w_next_state     = r_state;
    if (!rst) begin
      if (r_state == S_FLUSH) begin
        if (r_q == LAST_Q) begin
          instr_rd_en  = 1'b1;
          pc_incr_en   = 1'b1;
          w_next_state = S_EXEC;
        end
      end else if (r_q == EXEC_Q) begin
        alu_sel_l        = w_sel_l;
        alu_op           = w_op;
        alu_status_wr_en = w_status;
        w_wr_en          = w_wr_w;
        f_wr_en          = w_wr_f;
      end else if (r_q == LAST_Q) begin
        case (w_kind)
          K_SKIPZ, K_SKIPB: begin
            pc_incr_en = 1'b1;
            if (w_skip) begin
              instr_flush  = 1'b1;
              w_next_state = S_FLUSH;
            end else begin
              instr_rd_en = 1'b1;
            end
          end
          K_GOTO, K_CALL: begin
            pc_j_en      = 1'b1;
            instr_flush  = 1'b1;
            stack_push   = (w_kind == K_CALL);
            w_next_state = S_FLUSH;
          end
          K_RET, K_RETLW: begin
            pc_j_en      = 1'b1;
            pc_src_stack = 1'b1;
            stack_pop    = 1'b1;
            instr_flush  = 1'b1;
            w_next_state = S_FLUSH;
          end
          default: begin
            instr_rd_en   = 1'b1;
            pc_incr_en    = 1'b1;
            illegal_instr = (w_kind == K_ILL);
          end
        endcase
      end
    end
  end

  assign q_phase   = rst ? 3'd0 : r_q;
  assign in_flush  = ~rst & (r_state == S_FLUSH);
  assign stack_ovf = ~rst & r_ovf;
  assign stack_unf = ~rst & r_unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= 3'd0;
      r_state <= S_EXEC;
      r_depth <= 5'd0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_q     <= (r_q == LAST_Q) ? 3'd0 : r_q + 3'd1;
      r_state <= w_next_state;
      if (stack_push) begin
        if (r_depth == DEPTH_MAX) r_ovf <= 1'b1;
        else r_depth <= r_depth + 5'd1;
      end else if (stack_pop) begin
        if (r_depth == 5'd0) r_unf <= 1'b1;
        else r_depth <= r_depth - 5'd1;
      end
    end
  end
endmodule
